// File: rtl/matrix_key_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_key_scanner
//  Description : ROWS x COLS switch-matrix scanner with whole-frame debounce,
//                debounced key map and a valid/ready key-event FIFO.
//                Optional macro KEY_RELEASE_EVENT_EN enables release events.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_key_scanner #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 1000,
    parameter  int DEBOUNCE   = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int N          = ROWS * COLS,
    localparam int CODE_W     = $clog2(N)
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ROWS-1:0]   ROW_OUT,
    input  logic [COLS-1:0]   COL_IN,
    output logic [CODE_W-1:0] KEY_CODE,
    output logic              KEY_REL,
    output logic              KEY_VALID,
    input  logic              KEY_READY,
    output logic [N-1:0]      KEY_STATE,
    output logic              OVERFLOW
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ST_W  = $clog2(DEBOUNCE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef KEY_RELEASE_EVENT_EN
    localparam int ENT_W = CODE_W + 1;
`else
    localparam int ENT_W = CODE_W;
`endif
    localparam logic [DIV_W-1:0]  c_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0]  c_ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ST_W-1:0]   c_ST_MAX   = ST_W'(DEBOUNCE - 1);
    localparam logic [CODE_W-1:0] c_IDX_LAST = CODE_W'(N - 1);
    localparam logic [PTR_W:0]    c_DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

    logic [DIV_W-1:0]  r_div;
    logic [ROW_W-1:0]  r_row;
    logic [N-1:0]      r_raw;
    logic [N-1:0]      r_prev;
    logic              r_frame_done;
    logic [ST_W-1:0]   r_stable;
    logic [ST_W-1:0]   w_stable_nxt;
    logic              w_commit;
    logic [N-1:0]      r_key_state;
    logic [N-1:0]      r_pending;
    logic [N-1:0]      r_newmap;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_idx;
    logic              w_push;
    logic [ENT_W-1:0]  w_entry;
    logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [ENT_W-1:0]  w_head;
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W:0]    r_count;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              r_overflow;
`ifdef KEY_RELEASE_EVENT_EN
    logic              w_rel;
`endif

    // Row scan: each row is driven for SCAN_DIV cycles and sampled on its last.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div        <= '0;
            r_row        <= '0;
            r_raw        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_div == c_DIV_LAST) begin
                r_div                          <= '0;
                r_raw[int'(r_row)*COLS +: COLS] <= ~COL_IN;
                r_frame_done                   <= (r_row == c_ROW_LAST);
                r_row                          <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign ROW_OUT = ~(ROWS'(1) << r_row);

    always_comb begin
        w_stable_nxt = '0;
        if (r_raw == r_prev)
            w_stable_nxt = (r_stable == c_ST_MAX) ? r_stable : r_stable + 1'b1;
    end

    // Compare runs the cycle after the last row sample, once the frame is registered.
    assign w_commit = r_frame_done && (w_stable_nxt == c_ST_MAX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev      <= '0;
            r_stable    <= '0;
            r_key_state <= '0;
            r_pending   <= '0;
            r_newmap    <= '0;
        end else if (r_frame_done) begin
            r_prev   <= r_raw;
            r_stable <= w_stable_nxt;
            if (w_commit) begin
                r_key_state <= r_raw;
                r_pending   <= r_raw ^ r_key_state;
                r_newmap    <= r_raw;
            end
        end
    end

    assign KEY_STATE = r_key_state;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
`ifdef KEY_RELEASE_EVENT_EN
        w_rel       = 1'b0;
`endif
        case (r_state)
            S_IDLE: if (w_commit) w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (r_pending[r_idx] && r_newmap[r_idx]) w_push = 1'b1;
`ifdef KEY_RELEASE_EVENT_EN
                else if (r_pending[r_idx]) begin
                    w_push = 1'b1;
                    w_rel  = 1'b1;
                end
`endif
                if (r_idx == c_IDX_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET || r_state == S_IDLE) r_idx <= '0;
        else                            r_idx <= r_idx + 1'b1;
    end

`ifdef KEY_RELEASE_EVENT_EN
    assign w_entry = {w_rel, r_idx};
`else
    assign w_entry = r_idx;
`endif

    // When full, a simultaneous pop frees the slot being written this edge.
    assign w_full = (r_count == c_DEPTH);
    assign w_pop  = (r_count != '0) && KEY_READY;
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wr] <= w_entry;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign w_head    = r_mem[r_rd];
    assign KEY_VALID = (r_count != '0);
    assign KEY_CODE  = KEY_VALID ? w_head[CODE_W-1:0] : '0;
`ifdef KEY_RELEASE_EVENT_EN
    assign KEY_REL   = KEY_VALID && w_head[CODE_W];
`else
    assign KEY_REL   = 1'b0;
`endif
    assign OVERFLOW  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_matrix_key_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_key_scanner
//  Description : Self-checking bench for matrix_key_scanner (4x4, SCAN_DIV=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_key_scanner;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  ROW_OUT;
    logic [3:0]  COL_IN;
    logic [3:0]  KEY_CODE;
    logic        KEY_REL;
    logic        KEY_VALID;
    logic        KEY_READY = 1'b1;
    logic [15:0] KEY_STATE;
    logic        OVERFLOW;

    logic [15:0] keys = '0;
    logic [4:0]  evq [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [15:0] keys;
        logic [15:0] st;
        int          n;
        logic [14:0] ev;
    } vec_t;
    vec_t vecs [7];

    matrix_key_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ROW_OUT(ROW_OUT), .COL_IN(COL_IN),
        .KEY_CODE(KEY_CODE), .KEY_REL(KEY_REL), .KEY_VALID(KEY_VALID),
        .KEY_READY(KEY_READY), .KEY_STATE(KEY_STATE), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Switch matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        COL_IN = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!ROW_OUT[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) COL_IN[c] = 1'b0;
    end

    always @(negedge CLK)
        if (KEY_VALID && KEY_READY) evq.push_back({KEY_REL, KEY_CODE});

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc(2);
        RESET = 1'b0;
        evq.delete();
    endtask

    initial begin
        // {keys, KEY_STATE, event count, events {rel,code} lowest first}
        vecs[0] = '{keys: 16'h0000, st: 16'h0000, n: 0, ev: 15'h0};
        vecs[1] = '{keys: 16'h0200, st: 16'h0200, n: 1, ev: {10'h0, 5'd9}};
        vecs[2] = '{keys: 16'h0200, st: 16'h0200, n: 0, ev: 15'h0};
        vecs[3] = '{keys: 16'h1208, st: 16'h1208, n: 2, ev: {5'h0, 5'd12, 5'd3}};
`ifdef KEY_RELEASE_EVENT_EN
        vecs[4] = '{keys: 16'h1008, st: 16'h1008, n: 1, ev: {10'h0, 5'h19}};
        vecs[5] = '{keys: 16'h0000, st: 16'h0000, n: 2, ev: {5'h0, 5'h1C, 5'h13}};
`else
        vecs[4] = '{keys: 16'h1008, st: 16'h1008, n: 0, ev: 15'h0};
        vecs[5] = '{keys: 16'h0000, st: 16'h0000, n: 0, ev: 15'h0};
`endif
        vecs[6] = '{keys: 16'h8001, st: 16'h8001, n: 2, ev: {5'h0, 5'd15, 5'd0}};

        // Reset values and first row advance
        keys = '0;
        do_reset();
        check("rst_row_out", 32'(ROW_OUT), 32'hE);
        check("rst_valid", 32'(KEY_VALID), 32'h0);
        check("rst_state", 32'(KEY_STATE), 32'h0);
        check("rst_ovf", 32'(OVERFLOW), 32'h0);
        check("rst_code", 32'(KEY_CODE), 32'h0);
        check("rst_rel", 32'(KEY_REL), 32'h0);
        cyc(7);
        check("row0_hold", 32'(ROW_OUT), 32'hE);
        cyc(1);
        check("row1", 32'(ROW_OUT), 32'hD);

        // Key 9 held from reset: commit on edge 97, push of index 9 on edge 107
        keys = 16'h0200;
        KEY_READY = 1'b0;
        do_reset();
        cyc(96);
        check("k9_state_pre", 32'(KEY_STATE), 32'h0);
        cyc(1);
        check("k9_state", 32'(KEY_STATE), 32'h0200);
        cyc(9);
        check("k9_valid_pre", 32'(KEY_VALID), 32'h0);
        cyc(2);
        check("k9_valid", 32'(KEY_VALID), 32'h1);
        check("k9_code", 32'(KEY_CODE), 32'd9);
        check("k9_rel", 32'(KEY_REL), 32'h0);
        cyc(50);
        check("k9_hold_code", 32'(KEY_CODE), 32'd9);
        KEY_READY = 1'b1;
        cyc(2);
        check("k9_valid_fall", 32'(KEY_VALID), 32'h0);
        cyc(96);
        check("k9_one_event", 32'(evq.size()), 32'd1);
        if (evq.size() > 0) check("k9_event", 32'(evq[0]), 32'd9);

        // Key 9 toggled every frame for 5 frames, then held
        keys = '0;
        do_reset();
        for (int f = 1; f <= 5; f++) begin
            keys = (f % 2 == 1) ? 16'h0200 : 16'h0000;
            cyc(32);
        end
        keys = 16'h0200;
        cyc(64);
        check("tog_no_event", 32'(evq.size()), 32'd0);
        check("tog_state_pre", 32'(KEY_STATE), 32'h0);
        cyc(20);
        check("tog_state", 32'(KEY_STATE), 32'h0200);
        check("tog_events", 32'(evq.size()), 32'd1);
        if (evq.size() > 0) check("tog_event", 32'(evq[0]), 32'd9);

        // Table-driven sequence of key maps
        keys = '0;
        do_reset();
        for (int v = 0; v < 7; v++) begin
            evq.delete();
            keys = vecs[v].keys;
            cyc(192);
            check($sformatf("vec%0d_state", v), 32'(KEY_STATE), 32'(vecs[v].st));
            check($sformatf("vec%0d_count", v), 32'(evq.size()), 32'(vecs[v].n));
            for (int k = 0; k < vecs[v].n && k < evq.size(); k++)
                check($sformatf("vec%0d_ev%0d", v, k), 32'(evq[k]), 32'(vecs[v].ev[k*5 +: 5]));
        end

        // FIFO overflow: five separate presses with the consumer stalled
        keys = '0;
        KEY_READY = 1'b0;
        do_reset();
        keys = 16'h0001; cyc(192);
        keys = 16'h0003; cyc(192);
        keys = 16'h0007; cyc(192);
        keys = 16'h0017; cyc(192);
        check("ovf_not_yet", 32'(OVERFLOW), 32'h0);
        check("ovf_head4", 32'(KEY_CODE), 32'h0);
        keys = 16'h0037; cyc(192);
        check("ovf_set", 32'(OVERFLOW), 32'h1);
        check("ovf_state", 32'(KEY_STATE), 32'h0037);
        check("ovf_head5", 32'(KEY_CODE), 32'h0);
        KEY_READY = 1'b1;
        cyc(10);
        check("ovf_drained", 32'(evq.size()), 32'd4);
        for (int k = 0; k < 4 && k < evq.size(); k++)
            check($sformatf("ovf_ev%0d", k), 32'(evq[k]), (k == 3) ? 32'd4 : 32'(k));
        check("ovf_valid_fall", 32'(KEY_VALID), 32'h0);
        check("ovf_sticky", 32'(OVERFLOW), 32'h1);

        // Reset in the middle of EMIT discards queued and pending events
        keys = 16'hFFFF;
        KEY_READY = 1'b0;
        do_reset();
        cyc(100);
        check("memit_valid", 32'(KEY_VALID), 32'h1);
        RESET = 1'b1;
        cyc(1);
        check("memit_rst_valid", 32'(KEY_VALID), 32'h0);
        check("memit_rst_state", 32'(KEY_STATE), 32'h0);
        check("memit_rst_row", 32'(ROW_OUT), 32'hE);
        RESET = 1'b0;
        keys = '0;
        cyc(40);
        check("memit_no_residue", 32'(KEY_VALID), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
